aes_req_arbiter: RTL and testbench
==================================

Name: aes_req_arbiter

Overview:
- Shares one AES core (three-slot engine: enc_dec/is_valid/aes_in out; aes_ready/aes_busy/aes_out in) between two requesters inside xex_engine.
- Port 0 is the tweak path and port 1 is the data path.
- Arbitrates issue round-robin and keeps engine direction coherent by draining before any enc/dec switch.
- Tracks in-flight ownership in a tag FIFO so in-order engine results return to the issuing port.

Parameters:
- TAG_DEPTH, 4: tag FIFO entries, i.e. maximum blocks in flight. Must be >= 3 (engine slot count).
- CNT_W, 3: width of the in-flight counter. Must satisfy 2^CNT_W > TAG_DEPTH.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- req0_valid  in  1  port 0 has a block to encrypt/decrypt
- req0_enc_dec  in  1  port 0 direction: 0 = encrypt, 1 = decrypt
- req0_data  in  128  port 0 input block
- req0_grant  out  1  port 0 block accepted this cycle (combinational)
- req1_valid, req1_enc_dec, req1_data, req1_grant: same as port 0, for port 1
- rsp0_valid  out  1  one-cycle pulse: rsp0_data is port 0's result
- rsp0_data  out  128  registered result for port 0
- rsp1_valid, rsp1_data: same as port 0, for port 1
- ks_busy  in  1  key schedule load in progress; blocks issue
- enc_dec  out  1  direction to the engine
- is_valid  out  1  block offered to the engine
- aes_in  out  128  block to the engine
- aes_ready  in  1  engine result valid (one cycle per result)
- aes_busy  in  1  all engine slots occupied
- aes_out  in  128  engine result
- err  out  1  sticky: aes_ready seen with an empty tag FIFO

Behaviour:
Reset (n_rst low):
- Tag FIFO emptied; count = 0; state = IDLE; rr_ptr = 0; cur_dir = 0.
- rsp*_valid = 0, rsp*_data = 0, err = 0.
- is_valid and grants are forced to 0 while n_rst is low.

Eligibility (port i):
- reqi_valid = 1, ks_busy = 0, count < TAG_DEPTH, state != DRAIN, and (count == 0 or reqi_enc_dec == cur_dir).

Selection (combinational):
- If one port is eligible, select it.
- If both are eligible, select the port given by rr_ptr.
- is_valid = any port selected.
- aes_in and enc_dec are muxed from the selected port. When nothing is selected, both are 0.

Issue:
- An issue occurs in a cycle with is_valid = 1 and aes_busy = 0; the engine samples at that posedge.
- reqi_grant = 1 in that cycle for the selected port only.
- At the posedge: push the port id into the FIFO; count += 1; cur_dir <= selected enc_dec; rr_ptr <= other port.
- is_valid may be held while aes_busy = 1. No grant is given and the offer may change the next cycle.

Return:
- In a cycle with aes_ready = 1 and count > 0: pop the head tag and count -= 1.
- Next cycle: rsp<tag>_valid = 1 and rsp<tag>_data = aes_out as sampled; the other port's rsp valid = 0. Latency is exactly 1 cycle from aes_ready.
- rsp*_data holds its value until the next response for that port.
- aes_ready with count == 0: result dropped, no rsp pulse, err <= 1. err is cleared only by reset.
- Issue and return in the same cycle: push and pop both occur; count unchanged; FIFO order preserved.

State machine:
- IDLE (count = 0): any eligible port issues. An issue moves to ACTIVE.
- ACTIVE (count > 0): same-direction requests issue.
  - If any req_valid port has enc_dec != cur_dir (and ks_busy = 0), go to DRAIN.
  - If count reaches 0 with no blocked request, go to IDLE.
- DRAIN: no issue from either port, so a direction switch cannot be starved. When count reaches 0, go to IDLE. The waiting port is then eligible in the following cycle.

Other rules:
- ks_busy = 1 stalls issue only. Returns continue and the state machine still advances.
- Count is saturating-safe: pushes are impossible at TAG_DEPTH, and pops are impossible at 0.
- Reset mid-operation abandons in-flight tags. The engine shares n_rst, so no stale results are expected; any stale result that arrives sets err.

Test Plan:
- Single request: req0 enc, req0_data = 128'h00112233445566778899aabbccddeeff, engine returns X at cycle +16 -> req0_grant the same cycle as is_valid; rsp0_valid one cycle after aes_ready with rsp0_data = X; rsp1_valid stays 0.
- Contention: req0 and req1 both valid, encrypt, continuously for 6 grants -> grants alternate 0,1,0,1,0,1 starting with port 0 after reset; responses routed in issue order to matching ports.
- Backpressure: aes_busy held 1 for 5 cycles with req1_valid = 1 -> is_valid = 1 and req1_grant = 0 for those 5 cycles; exactly one grant on the first cycle aes_busy = 0. With TAG_DEPTH = 4 and no returns, the 5th request is never granted.
- Direction switch: 2 encrypt blocks in flight from port 1, then req0_enc_dec = 1 -> DRAIN; no grants (port 1 encrypt included) until both results return; then port 0 is granted with enc_dec = 1.
- Same-cycle push/pop: aes_ready = 1 coincident with an issue at count = 2 -> count stays 2; tag order verified by distinct payloads 128'h1, 128'h2, 128'h3.
- Error/reset: aes_ready with count = 0 -> err = 1 next cycle, no rsp pulse. Assert n_rst mid-stream with 3 blocks in flight -> all outputs 0 and count 0; err cleared.

Source files
------------

// File: rtl/aes_req_arbiter_if.sv
// aes_req_arbiter_if: requester, response and AES engine signals of the shared-engine arbiter.
interface aes_req_arbiter_if;
    logic         req0_valid, req0_enc_dec, req0_grant;
    logic [127:0] req0_data;
    logic         req1_valid, req1_enc_dec, req1_grant;
    logic [127:0] req1_data;
    logic         rsp0_valid, rsp1_valid;
    logic [127:0] rsp0_data, rsp1_data;
    logic         ks_busy;
    logic         enc_dec, is_valid, aes_ready, aes_busy, err;
    logic [127:0] aes_in, aes_out;

    modport slave (
        input  req0_valid, req0_enc_dec, req0_data, req1_valid, req1_enc_dec, req1_data,
               ks_busy, aes_ready, aes_busy, aes_out,
        output req0_grant, req1_grant, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
               enc_dec, is_valid, aes_in, err
    );
    modport master (
        output req0_valid, req0_enc_dec, req0_data, req1_valid, req1_enc_dec, req1_data,
               ks_busy, aes_ready, aes_busy, aes_out,
        input  req0_grant, req1_grant, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
               enc_dec, is_valid, aes_in, err
    );
endinterface

// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: round-robin sharing of one AES engine between the tweak (0) and data (1) paths.
// The engine is drained before any direction change; a tag FIFO routes in-order results to the issuer.
module aes_req_arbiter #(
    parameter int TAG_DEPTH = 4,
    parameter int CNT_W     = 3
) (
    input logic              clk,
    input logic              n_rst,
    aes_req_arbiter_if.slave bus
);
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [TAG_DEPTH-1:0] r_tag;
    logic                 r_rr_ptr, r_cur_dir, r_err;
    logic                 r_rsp0_valid, r_rsp1_valid;
    logic [127:0]         r_rsp0_data, r_rsp1_data;

    logic             w_open, w_elig0, w_elig1, w_sel0, w_sel1;
    logic             w_issue, w_pop, w_head, w_block;
    logic [CNT_W-1:0] w_cnt_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A mixed-direction request may only join an empty engine.
    assign w_open  = n_rst && !bus.ks_busy && (r_cnt < CNT_W'(TAG_DEPTH)) && (r_state != DRAIN);
    assign w_elig0 = w_open && bus.req0_valid && (r_cnt == '0 || bus.req0_enc_dec == r_cur_dir);
    assign w_elig1 = w_open && bus.req1_valid && (r_cnt == '0 || bus.req1_enc_dec == r_cur_dir);
    assign w_sel0  = w_elig0 && (!w_elig1 || !r_rr_ptr);
    assign w_sel1  = w_elig1 && (!w_elig0 || r_rr_ptr);

    assign w_issue   = (w_sel0 || w_sel1) && !bus.aes_busy;
    assign w_pop     = bus.aes_ready && (r_cnt != '0);
    assign w_head    = r_tag[r_rd_ptr];
    assign w_block   = !bus.ks_busy && ((bus.req0_valid && bus.req0_enc_dec != r_cur_dir) ||
                                        (bus.req1_valid && bus.req1_enc_dec != r_cur_dir));
    assign w_cnt_nxt = r_cnt + CNT_W'(w_issue) - CNT_W'(w_pop);

    assign bus.is_valid   = w_sel0 || w_sel1;
    assign bus.enc_dec    = (w_sel0 && bus.req0_enc_dec) || (w_sel1 && bus.req1_enc_dec);
    assign bus.aes_in     = w_sel1 ? bus.req1_data : (w_sel0 ? bus.req0_data : '0);
    assign bus.req0_grant = w_issue && w_sel0;
    assign bus.req1_grant = w_issue && w_sel1;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp0_data  = r_rsp0_data;
    assign bus.rsp1_data  = r_rsp1_data;
    assign bus.err        = r_err;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_tag        <= '0;
            r_rr_ptr     <= 1'b0;
            r_cur_dir    <= 1'b0;
            r_err        <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
        end else begin
            if (w_issue) begin
                r_tag[r_wr_ptr] <= w_sel1;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
                r_cur_dir       <= bus.enc_dec;
                r_rr_ptr        <= !w_sel1;
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_pop && !w_head) r_rsp0_data <= bus.aes_out;
            if (w_pop && w_head) r_rsp1_data <= bus.aes_out;
            if (bus.aes_ready && r_cnt == '0) r_err <= 1'b1;
            r_cnt        <= w_cnt_nxt;
            r_rsp0_valid <= w_pop && !w_head;
            r_rsp1_valid <= w_pop && w_head;
            // A blocked opposite-direction request wins over returning to IDLE.
            case (r_state)
                IDLE:    r_state <= w_issue ? ACTIVE : IDLE;
                ACTIVE:  r_state <= w_block ? DRAIN : (w_cnt_nxt == '0 ? IDLE : ACTIVE);
                DRAIN:   r_state <= (w_cnt_nxt == '0) ? IDLE : DRAIN;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter: directed and random stimulus for aes_req_arbiter, checked every cycle
// against a queue-based model of issue, drain and in-order return routing.
module tb_aes_req_arbiter;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    always #5 clk = ~clk;

    aes_req_arbiter_if bus ();
    aes_req_arbiter #(.TAG_DEPTH(DEPTH), .CNT_W(3)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    int           m_q[$];
    bit           m_drain, m_dir, m_rr, m_err;
    bit           m_rv[2];
    logic [127:0] m_rd[2];
    int           m_sel;
    int           n_pass = 0, n_chk = 0;
    logic         obs_v, obs_g0, obs_g1, obs_ed, sw_g;
    localparam logic [127:0] X_SINGLE = 128'hdeadbeef_0badf00d_12345678_9abcdef0;

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %b want %b", tag, obs, exp);
    endtask

    task automatic chkd(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic idle_in();
        bus.req0_valid = 0; bus.req0_enc_dec = 0; bus.req0_data = '0;
        bus.req1_valid = 0; bus.req1_enc_dec = 0; bus.req1_data = '0;
        bus.ks_busy = 0; bus.aes_ready = 0; bus.aes_busy = 0; bus.aes_out = '0;
    endtask

    task automatic do_reset();
        n_rst = 0;
        #2;
        chkb("rst_is_valid", bus.is_valid, 1'b0);
        chkb("rst_grant0", bus.req0_grant, 1'b0);
        chkb("rst_grant1", bus.req1_grant, 1'b0);
        chkb("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        chkb("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
        chkb("rst_err", bus.err, 1'b0);
        chkd("rst_rsp0_data", bus.rsp0_data, '0);
        chkd("rst_rsp1_data", bus.rsp1_data, '0);
        chkd("rst_aes_in", bus.aes_in, '0);
        chkd("rst_count", 128'(dut.r_cnt), 128'(0));
        @(posedge clk);
        #1;
        n_rst = 1;
        m_q.delete();
        m_drain = 0; m_dir = 0; m_rr = 0; m_err = 0;
        m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = '0; m_rd[1] = '0;
    endtask

    // One clock: check the combinational offer, advance the model at the edge, check the responses.
    task automatic cyc();
        bit e0, e1, mis;
        int old, t;
        #2;
        e0 = bus.req0_valid && !bus.ks_busy && m_q.size() < DEPTH && !m_drain &&
             (m_q.size() == 0 || bus.req0_enc_dec == m_dir);
        e1 = bus.req1_valid && !bus.ks_busy && m_q.size() < DEPTH && !m_drain &&
             (m_q.size() == 0 || bus.req1_enc_dec == m_dir);
        m_sel = (e0 && e1) ? int'(m_rr) : e0 ? 0 : e1 ? 1 : -1;
        chkb("is_valid", bus.is_valid, m_sel >= 0);
        chkb("grant0", bus.req0_grant, m_sel == 0 && !bus.aes_busy);
        chkb("grant1", bus.req1_grant, m_sel == 1 && !bus.aes_busy);
        chkb("enc_dec", bus.enc_dec, m_sel == 0 ? bus.req0_enc_dec : m_sel == 1 ? bus.req1_enc_dec : 1'b0);
        chkd("aes_in", bus.aes_in, m_sel == 0 ? bus.req0_data : m_sel == 1 ? bus.req1_data : 128'h0);
        obs_v = bus.is_valid; obs_g0 = bus.req0_grant; obs_g1 = bus.req1_grant; obs_ed = bus.enc_dec;
        mis = !bus.ks_busy && ((bus.req0_valid && bus.req0_enc_dec != m_dir) ||
                               (bus.req1_valid && bus.req1_enc_dec != m_dir));
        old = m_q.size();
        @(posedge clk);
        m_rv[0] = 0; m_rv[1] = 0;
        if (bus.aes_ready) begin
            if (old > 0) begin
                t = m_q.pop_front();
                m_rv[t] = 1;
                m_rd[t] = bus.aes_out;
            end else m_err = 1;
        end
        if (m_sel >= 0 && !bus.aes_busy) begin
            m_q.push_back(m_sel);
            m_dir = (m_sel == 0) ? bus.req0_enc_dec : bus.req1_enc_dec;
            m_rr = (m_sel == 0);
        end
        m_drain = m_drain ? (m_q.size() != 0) : (old > 0 && mis);
        #1;
        chkb("rsp0_valid", bus.rsp0_valid, m_rv[0]);
        chkb("rsp1_valid", bus.rsp1_valid, m_rv[1]);
        chkd("rsp0_data", bus.rsp0_data, m_rd[0]);
        chkd("rsp1_data", bus.rsp1_data, m_rd[1]);
        chkb("err", bus.err, m_err);
    endtask

    initial begin
        idle_in();
        #1;
        do_reset();

        // Single request, result 16 cycles later
        bus.req0_valid = 1; bus.req0_data = 128'h00112233445566778899aabbccddeeff;
        cyc();
        chkb("single_grant0", obs_g0, 1'b1);
        chkb("single_grant1", obs_g1, 1'b0);
        bus.req0_valid = 0;
        repeat (15) cyc();
        bus.aes_ready = 1; bus.aes_out = X_SINGLE;
        cyc();
        bus.aes_ready = 0;
        chkb("single_rsp0_valid", bus.rsp0_valid, 1'b1);
        chkd("single_rsp0_data", bus.rsp0_data, X_SINGLE);
        chkb("single_rsp1_valid", bus.rsp1_valid, 1'b0);

        // Contention: strict alternation from port 0
        do_reset();
        bus.req0_valid = 1; bus.req1_valid = 1;
        for (int i = 0; i < 6; i++) begin
            bus.req0_data = 128'(100 + i); bus.req1_data = 128'(200 + i);
            bus.aes_ready = (i > 0); bus.aes_out = 128'(300 + i);
            cyc();
            chkb("cont_grant0", obs_g0, (i % 2) == 0);
            chkb("cont_grant1", obs_g1, (i % 2) == 1);
        end
        bus.req0_valid = 0; bus.req1_valid = 0; bus.aes_out = 128'(306);
        cyc();
        bus.aes_ready = 0;

        // Backpressure and tag FIFO full
        do_reset();
        bus.req1_valid = 1; bus.aes_busy = 1;
        repeat (5) begin
            cyc();
            chkb("bp_is_valid", obs_v, 1'b1);
            chkb("bp_grant1", obs_g1, 1'b0);
        end
        bus.aes_busy = 0;
        for (int i = 0; i < 5; i++) begin
            bus.req1_data = 128'(i + 1);
            cyc();
            chkb("bp_free_grant1", obs_g1, i < 4);
        end
        chkd("bp_full_count", 128'(dut.r_cnt), 128'(4));
        bus.req1_valid = 0; bus.aes_ready = 1;
        for (int i = 0; i < 4; i++) begin
            bus.aes_out = 128'(500 + i);
            cyc();
        end
        bus.aes_ready = 0;

        // Direction switch: drain before decrypt
        bus.req1_valid = 1; bus.req1_enc_dec = 0; bus.req1_data = 128'h77;
        repeat (2) cyc();
        bus.req1_valid = 0; bus.req0_valid = 1; bus.req0_enc_dec = 1; bus.req0_data = 128'h99;
        cyc();
        sw_g = obs_g0 | obs_g1;
        bus.req1_valid = 1;
        cyc();
        sw_g |= obs_g0 | obs_g1;
        bus.aes_ready = 1;
        for (int i = 0; i < 2; i++) begin
            bus.aes_out = 128'(600 + i);
            cyc();
            sw_g |= obs_g0 | obs_g1;
        end
        bus.aes_ready = 0;
        cyc();
        chkb("sw_no_grant_in_drain", sw_g, 1'b0);
        chkb("sw_grant0", obs_g0, 1'b1);
        chkb("sw_enc_dec", obs_ed, 1'b1);
        bus.req0_valid = 0; bus.req1_valid = 0; bus.aes_ready = 1; bus.aes_out = 128'h600d;
        cyc();
        bus.aes_ready = 0;
        cyc();

        // Same-cycle push and pop keeps count and order
        do_reset();
        bus.req0_valid = 1; bus.req0_enc_dec = 0; bus.req0_data = 128'h1;
        cyc();
        bus.req0_valid = 0; bus.req1_valid = 1; bus.req1_enc_dec = 0; bus.req1_data = 128'h2;
        cyc();
        bus.req1_valid = 0; bus.req0_valid = 1; bus.req0_data = 128'h3;
        bus.aes_ready = 1; bus.aes_out = 128'h1;
        cyc();
        chkd("pp_count", 128'(dut.r_cnt), 128'(2));
        chkb("pp_rsp0_valid", bus.rsp0_valid, 1'b1);
        chkd("pp_rsp0_data", bus.rsp0_data, 128'h1);
        bus.req0_valid = 0; bus.aes_out = 128'h2;
        cyc();
        chkb("pp_rsp1_valid", bus.rsp1_valid, 1'b1);
        chkd("pp_rsp1_data", bus.rsp1_data, 128'h2);
        bus.aes_out = 128'h3;
        cyc();
        chkb("pp_rsp0_valid_2", bus.rsp0_valid, 1'b1);
        chkd("pp_rsp0_data_2", bus.rsp0_data, 128'h3);

        // Stray result sets err; reset mid-stream clears everything
        bus.aes_out = 128'hbad;
        cyc();
        bus.aes_ready = 0;
        chkb("err_set", bus.err, 1'b1);
        chkb("err_no_rsp0", bus.rsp0_valid, 1'b0);
        chkb("err_no_rsp1", bus.rsp1_valid, 1'b0);
        bus.req1_valid = 1; bus.req1_data = 128'h4;
        repeat (3) cyc();
        chkd("pre_rst_count", 128'(dut.r_cnt), 128'(3));
        do_reset();

        // Random traffic against the model
        idle_in();
        for (int i = 0; i < 400; i++) begin
            bus.req0_valid = $urandom_range(0, 99) < 60;
            bus.req1_valid = $urandom_range(0, 99) < 60;
            bus.req0_enc_dec = $urandom_range(0, 99) < 25;
            bus.req1_enc_dec = $urandom_range(0, 99) < 25;
            bus.req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.req1_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.ks_busy = $urandom_range(0, 99) < 8;
            bus.aes_busy = $urandom_range(0, 99) < 15;
            bus.aes_ready = m_q.size() > 0 && $urandom_range(0, 99) < 40;
            bus.aes_out = {$urandom(), $urandom(), $urandom(), $urandom()};
            cyc();
        end
        idle_in();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
